npu_stage_seq: RTL and testbench

//  Parametrised host-addressed sequencer for the NPU layer chain (conv1->conv2->fc1->fc2->...).

---
 rtl/npu_pkg.sv | 41 ++++
 rtl/npu_cmd_decode.sv | 69 ++++++
 rtl/npu_stage_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_npu_stage_seq.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared codes for the NPU stage sequencer: region/op codes, FSM state encoding, status word layout.
package npu_pkg;

  localparam logic [2:0] REGION_OP = 3'd5;

  localparam logic [11:0] OP_RST  = 12'd0;
  localparam logic [11:0] OP_TRIG = 12'd1;
  localparam logic [11:0] OP_REQ  = 12'd2;
  localparam logic [11:0] OP_STAT = 12'd3;
  localparam logic [11:0] OP_MASK = 12'd4;
  localparam logic [11:0] OP_ECLR = 12'd5;
  localparam logic [11:0] OP_TMO  = 12'd6;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSel    = 3'd1,
    StLaunch = 3'd2,
    StWait   = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam int unsigned STAT_STATE_LSB = 4;
  localparam int unsigned STAT_CUR_LSB   = 7;
  localparam int unsigned STAT_BUSY      = 10;
  localparam int unsigned STAT_DONE      = 11;
  localparam int unsigned STAT_ERR_LSB   = 12;

  function automatic logic [31:0] pack_status(input logic [3:0] err, input logic done,
                                              input logic busy, input logic [2:0] cur,
                                              input state_e st);
    logic [31:0] s;
    s = '0;
    s[STAT_ERR_LSB +: 4]   = err;
    s[STAT_DONE]           = done;
    s[STAT_BUSY]           = busy;
    s[STAT_CUR_LSB +: 3]   = cur;
    s[STAT_STATE_LSB +: 3] = st;
    return s;
  endfunction

endpackage

// File: rtl/npu_cmd_decode.sv
// Host access decoder: registers each access and splits it into op-region requests and
// load-buffer writes. Load writes are dropped (and flagged) while the sequencer is busy.
module npu_cmd_decode import npu_pkg::*; #(
  parameter int unsigned N_REGIONS = 5,
  parameter int unsigned MASK_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [14:0]       addr,
  input  logic [31:0]       w_data,
  input  logic              busy,
  output logic              op_valid,
  output logic              op_we,
  output logic [11:0]       op_code,
  output logic [MASK_W-1:0] op_data,
  output logic              rd_valid,
  output logic              bad_region,
  output logic              ld_valid,
  output logic [2:0]        ld_region,
  output logic [11:0]       ld_index,
  output logic [31:0]       ld_data,
  output logic              ld_drop
);

  logic [2:0] region;
  logic       is_op, is_load, ld_acc;

  always_comb begin
    region  = addr[14:12];
    is_op   = (region == REGION_OP);
    is_load = !is_op && (32'(region) < N_REGIONS);
    ld_acc  = en && we && is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid   <= 1'b0;
      op_we      <= 1'b0;
      op_code    <= '0;
      op_data    <= '0;
      rd_valid   <= 1'b0;
      bad_region <= 1'b0;
      ld_valid   <= 1'b0;
      ld_region  <= '0;
      ld_index   <= '0;
      ld_data    <= '0;
      ld_drop    <= 1'b0;
    end else begin
      op_valid   <= en && is_op;
      rd_valid   <= en && !we;
      bad_region <= en && !is_op && !is_load;
      ld_valid   <= ld_acc && !busy;
      ld_drop    <= ld_acc && busy;
      if (en) begin
        op_we   <= we;
        op_code <= addr[11:0];
        op_data <= w_data[MASK_W-1:0];
      end
      if (ld_acc && !busy) begin
        ld_region <= region;
        ld_index  <= addr[11:0];
        ld_data   <= w_data;
      end
    end
  end

endmodule

// File: rtl/npu_stage_seq.sv
// Host-addressed sequencer running masked start/done handshakes over a chain of NPU layer stages.
// Optional per-stage watchdog enabled by defining STAGE_TIMEOUT_EN.
module npu_stage_seq import npu_pkg::*; #(
  parameter int unsigned N_STAGES  = 4,
  parameter int unsigned RES_W     = 24,
  parameter int unsigned N_REGIONS = 5,
  parameter int unsigned TMO_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [14:0]         addr,
  input  logic [31:0]         w_data,
  output logic [31:0]         r_data,
  output logic                r_valid,
  output logic                ld_valid,
  output logic [2:0]          ld_region,
  output logic [11:0]         ld_index,
  output logic [31:0]         ld_data,
  output logic [N_STAGES-1:0] stage_start,
  input  logic [N_STAGES-1:0] stage_done,
  output logic                stage_abort,
  input  logic [RES_W-1:0]    result_in,
  output logic                busy,
  output logic                done
);

  logic                op_valid, op_we, rd_valid, bad_region, ld_drop;
  logic [11:0]         op_code;
  logic [N_STAGES-1:0] op_data;

  state_e              state_q;
  logic [2:0]          cur_q;
  logic [N_STAGES-1:0] mask_q, start_q;
  logic [3:0]          err_q, err_set;
  logic [RES_W-1:0]    res_q;
  logic                busy_q, done_q, abort_q;

  logic                wr_op, soft_rst, trig, mask_wr, err_clr, op_ok;
  logic                done_hit, sel_found, tmo_fire;
  logic [2:0]          sel_idx;
  logic [7:0]          done_ext;
  logic [N_STAGES-1:0] sel_onehot;

`ifdef STAGE_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
  localparam logic [TMO_W-1:0] TmoLast = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] tmo_q;
`else
  localparam bit TmoEn = 1'b0;
`endif

  npu_cmd_decode #(
    .N_REGIONS (N_REGIONS),
    .MASK_W    (N_STAGES)
  ) u_decode (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .we         (we),
    .addr       (addr),
    .w_data     (w_data),
    .busy       (busy_q),
    .op_valid   (op_valid),
    .op_we      (op_we),
    .op_code    (op_code),
    .op_data    (op_data),
    .rd_valid   (rd_valid),
    .bad_region (bad_region),
    .ld_valid   (ld_valid),
    .ld_region  (ld_region),
    .ld_index   (ld_index),
    .ld_data    (ld_data),
    .ld_drop    (ld_drop)
  );

  always_comb begin
    wr_op    = op_valid && op_we;
    soft_rst = wr_op && (op_code == OP_RST);
    trig     = wr_op && (op_code == OP_TRIG);
    mask_wr  = wr_op && (op_code == OP_MASK);
    err_clr  = wr_op && (op_code == OP_ECLR);
    if (op_we) begin
      op_ok = op_code inside {OP_RST, OP_TRIG, OP_MASK, OP_ECLR};
    end else begin
      op_ok = (op_code inside {OP_REQ, OP_STAT}) || (TmoEn && (op_code == OP_TMO));
    end
    // Only the stage currently being waited on may complete it.
    done_ext = 8'(stage_done);
    done_hit = (state_q == StWait) && done_ext[cur_q];
`ifdef STAGE_TIMEOUT_EN
    tmo_fire = (state_q == StWait) && !done_hit && (tmo_q == TmoLast);
`else
    tmo_fire = 1'b0;
`endif
    err_set = {tmo_fire,
               bad_region || (op_valid && !op_ok),
               ld_drop || (mask_wr && busy_q),
               trig && busy_q};
  end

  // Lowest enabled stage at or above the current position.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (mask_q[i] && (32'(i) >= 32'(cur_q))) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
    for (int i = 0; i < N_STAGES; i++) begin
      sel_onehot[i] = sel_found && (3'(i) == sel_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      mask_q  <= '1;
      err_q   <= '0;
      res_q   <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef STAGE_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else if (soft_rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      err_q   <= '0;
      res_q   <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= busy_q;
`ifdef STAGE_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      start_q <= '0;
      abort_q <= 1'b0;
      err_q   <= err_clr ? err_set : (err_q | err_set);
      if (mask_wr && !busy_q) begin
        mask_q <= op_data;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (trig) begin
            state_q <= StSel;
            cur_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StSel: begin
          if (sel_found) begin
            cur_q   <= sel_idx;
            start_q <= sel_onehot;
            state_q <= StLaunch;
          end else begin
            res_q   <= result_in;
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StLaunch: begin
          state_q <= StWait;
`ifdef STAGE_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        StWait: begin
          if (done_hit) begin
            cur_q   <= cur_q + 3'd1;
            state_q <= StSel;
          end else if (tmo_fire) begin
            abort_q <= 1'b1;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
`ifdef STAGE_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    r_data = '0;
    if (rd_valid && op_valid) begin
      if (op_code == OP_REQ) begin
        r_data = 32'($signed(res_q));
      end else if (op_code == OP_STAT) begin
        r_data = pack_status(err_q, done_q, busy_q, cur_q, state_q);
      end
`ifdef STAGE_TIMEOUT_EN
      else if (op_code == OP_TMO) begin
        r_data = 32'(tmo_q);
      end
`endif
    end
  end

  assign r_valid     = rd_valid;
  assign stage_start = start_q;
  assign stage_abort = abort_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_npu_stage_seq.sv
// Self-checking bench for npu_stage_seq: randomized jobs checked against a stage-order/latency model.
module tb_npu_stage_seq;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, we;
  logic [14:0]   addr;
  logic [31:0]   w_data;
  logic [31:0]   r_data;
  logic          r_valid;
  logic          ld_valid;
  logic [2:0]    ld_region;
  logic [11:0]   ld_index;
  logic [31:0]   ld_data;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done = '0;
  logic          stage_abort;
  logic [23:0]   result_in;
  logic          busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  npu_stage_seq #(
    .N_STAGES  (NS),
    .RES_W     (24),
    .N_REGIONS (5),
    .TMO_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .we          (we),
    .addr        (addr),
    .w_data      (w_data),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .ld_valid    (ld_valid),
    .ld_region   (ld_region),
    .ld_index    (ld_index),
    .ld_data     (ld_data),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .stage_abort (stage_abort),
    .result_in   (result_in),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Layer-stage responder: answers each start with a done pulse 5 cycles later; logs every start.
  bit auto_done = 1'b1;
  int cnt[NS];
  int start_k[$];
  int start_c[$];
  int abort_n = 0;
  int abort_c = -1;

  always @(negedge clk) begin
    stage_done = '0;
    for (int k = 0; k < NS; k++) begin
      if (cnt[k] > 0) begin
        cnt[k] = cnt[k] - 1;
        if (cnt[k] == 0) stage_done[k] = 1'b1;
      end
      if (stage_start[k] === 1'b1) begin
        start_k.push_back(k);
        start_c.push_back(cyc);
        if (auto_done) cnt[k] = 5;
      end
    end
    if (stage_abort === 1'b1) begin
      abort_n++;
      abort_c = cyc;
      for (int k = 0; k < NS; k++) cnt[k] = 0;
    end
  end

  function automatic logic [14:0] op_addr(input int op);
    logic [11:0] o;
    o = 12'(op);
    return {3'd5, o};
  endfunction

  function automatic logic [31:0] sext24(input logic [23:0] v);
    int s;
    s = int'(v);
    if (s >= (1 << 23)) s = s - (1 << 24);
    return 32'(s);
  endfunction

  // One host access; returns at the negedge where its registered response is visible.
  task automatic access(input bit w, input logic [14:0] a, input logic [31:0] d, output int c);
    @(negedge clk);
    en = 1'b1; we = w; addr = a; w_data = d; c = cyc;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic read_op(input int op, output logic [31:0] d, output logic v);
    int c;
    access(1'b0, op_addr(op), 32'h0, c);
    d = r_data; v = r_valid;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_order(input logic [3:0] m, input string nm);
    int exp_k[$];
    bit ok;
    for (int k = 0; k < NS; k++) if (m[k]) exp_k.push_back(k);
    ok = (start_k.size() == exp_k.size());
    if (ok) for (int i = 0; i < exp_k.size(); i++) if (start_k[i] != exp_k[i]) ok = 0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s order: got %0d starts %p, want %0d starts %p", nm, start_k.size(),
               start_k, exp_k.size(), exp_k);
    end
  endtask

  task automatic run_job(input bit wr_mask, input logic [3:0] m, input logic [23:0] res,
                         input string nm);
    int c, dc, n;
    bit ok;
    logic [31:0] d;
    logic v;
    result_in = res;
    if (wr_mask) access(1'b1, op_addr(4), {28'b0, m}, c);
    start_k.delete(); start_c.delete();
    access(1'b1, op_addr(1), 32'h0, c);
    @(negedge clk);
    wait_done(400, dc);
    @(negedge clk);
    n = $countones(m);
    check_order(m, nm);
    ok = (dc == c + 3 + 7 * n);
    for (int i = 0; i < start_c.size(); i++) if (start_c[i] != c + 3 + 7 * i) ok = 0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s timing: trig %0d starts %p done@%0d, want first %0d step 7 done@%0d",
               nm, c, start_c, dc, c + 3, c + 3 + 7 * n);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done/busy: got %b/%b want 1/0", nm, done, busy);
    end
    read_op(2, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== sext24(res)) begin
      n_bad++;
      $display("FAIL %s require: got v=%b %h want v=1 %h", nm, v, d, sext24(res));
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; w_data = '0; result_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, stage_start, stage_abort, ld_valid, r_valid} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got %b want 0",
               {busy, done, stage_start, stage_abort, ld_valid, r_valid});
    end
    rst = 1'b0;
    read_op(3, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_bad++;
      $display("FAIL reset status: got v=%b %h want v=1 0", v, d);
    end
    read_op(2, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_bad++;
      $display("FAIL reset require: got v=%b %h want v=1 0", v, d);
    end
  endtask

  task automatic test_all_stages();
    run_job(1'b1, 4'b1111, 24'($urandom), "all");
  endtask

  task automatic test_mask();
    logic [31:0] d;
    logic v;
    logic [31:0] st;
    run_job(1'b1, 4'b0101, 24'hFFFFFB, "mask0101");
    read_op(2, d, v);
    n_cmp++;
    if (d !== 32'hFFFF_FFFB) begin
      n_bad++;
      $display("FAIL mask0101 require: got %h want FFFFFFFB", d);
    end
    read_op(3, st, v);
    n_cmp++;
    // err=0, done=1, busy=0, state=DONE(4); cur field not modelled
    if ((st & 32'hFFFF_FC7F) !== ((32'd1 << 11) | (32'd4 << 4))) begin
      n_bad++;
      $display("FAIL done status: got %h want %h (cur masked)", st & 32'hFFFF_FC7F,
               (32'd1 << 11) | (32'd4 << 4));
    end
    run_job(1'b1, 4'b0000, 24'($urandom), "mask0000");
    for (int i = 0; i < 3; i++) begin
      run_job(1'b1, 4'($urandom_range(1, 15)), 24'($urandom), "maskrand");
    end
  endtask

  task automatic test_busy_errors();
    int c;
    logic [31:0] st;
    logic v;
    result_in = 24'($urandom);
    access(1'b1, op_addr(4), 32'hF, c);
    start_k.delete(); start_c.delete();
    access(1'b1, op_addr(1), 32'h0, c);
    @(negedge clk);
    access(1'b1, op_addr(1), 32'h0, c);
    access(1'b1, {3'd1, 12'h055}, 32'hDEAD_BEEF, c);
    n_cmp++;
    if (ld_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL busy load drop: got ld_valid=%b want 0", ld_valid);
    end
    access(1'b1, op_addr(4), 32'h1, c);
    read_op(3, st, v);
    n_cmp++;
    if (st[15:12] !== 4'b0011 || st[10] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy err: got err=%b busy=%b want 0011/1", st[15:12], st[10]);
    end
    wait_done(400, c);
    @(negedge clk);
    check_order(4'b1111, "busy-mask-kept");
    access(1'b1, op_addr(5), 32'h0, c);
    read_op(3, st, v);
    n_cmp++;
    if (st[15:12] !== 4'b0000) begin
      n_bad++;
      $display("FAIL errclr: got err=%b want 0000", st[15:12]);
    end
    access(1'b1, op_addr(7), 32'h0, c);
    read_op(3, st, v);
    n_cmp++;
    if (st[15:12] !== 4'b0100) begin
      n_bad++;
      $display("FAIL unknown op err: got %b want 0100", st[15:12]);
    end
    access(1'b1, op_addr(5), 32'h0, c);
    access(1'b1, {3'd6, 12'h001}, 32'h1, c);
    read_op(3, st, v);
    n_cmp++;
    if (st[15:12] !== 4'b0100) begin
      n_bad++;
      $display("FAIL bad region err: got %b want 0100", st[15:12]);
    end
    access(1'b1, op_addr(5), 32'h0, c);
`ifndef STAGE_TIMEOUT_EN
    read_op(6, st, v);
    read_op(3, st, v);
    n_cmp++;
    if (st[15:12] !== 4'b0100) begin
      n_bad++;
      $display("FAIL op6 unknown err: got %b want 0100", st[15:12]);
    end
    access(1'b1, op_addr(5), 32'h0, c);
`endif
  endtask

  task automatic test_soft_rst();
    int c, n0, aborts0;
    logic [31:0] st;
    logic v;
    bit seen;
    access(1'b1, op_addr(4), 32'h6, c);
    start_k.delete(); start_c.delete();
    aborts0 = abort_n;
    access(1'b1, op_addr(1), 32'h0, c);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (start_k.size() >= 2) seen = 1;
    end
    access(1'b1, op_addr(0), 32'h0, c);
    @(negedge clk);
    n_cmp++;
    if (stage_abort !== 1'b1) begin
      n_bad++;
      $display("FAIL softrst abort pulse: got %b want 1", stage_abort);
    end
    @(negedge clk);
    n_cmp++;
    if (stage_abort !== 1'b0 || abort_n - aborts0 != 1) begin
      n_bad++;
      $display("FAIL softrst abort width: got %b count %0d want 0 count 1", stage_abort,
               abort_n - aborts0);
    end
    read_op(3, st, v);
    n_cmp++;
    if (st !== 32'h0) begin
      n_bad++;
      $display("FAIL softrst status: got %h want 0", st);
    end
    n0 = start_k.size();
    repeat (20) @(negedge clk);
    n_cmp++;
    if (start_k.size() != n0 || n0 != 2) begin
      n_bad++;
      $display("FAIL softrst starts: got %0d then %0d want 2 then 2", n0, start_k.size());
    end
    run_job(1'b0, 4'b0110, 24'($urandom), "softrst-mask-kept");
  endtask

  task automatic test_load();
    int c;
    logic [2:0] rg;
    logic [11:0] ix;
    logic [31:0] dd;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        rg = 3'd2; ix = 12'h07B; dd = 32'h12;
      end else begin
        rg = 3'($urandom_range(0, 4)); ix = 12'($urandom); dd = $urandom;
      end
      access(1'b1, {rg, ix}, dd, c);
      n_cmp++;
      if (ld_valid !== 1'b1 || ld_region !== rg || ld_index !== ix || ld_data !== dd) begin
        n_bad++;
        $display("FAIL load %0d: got v=%b r=%0d i=%h d=%h want v=1 r=%0d i=%h d=%h", i,
                 ld_valid, ld_region, ld_index, ld_data, rg, ix, dd);
      end
      @(negedge clk);
      n_cmp++;
      if (ld_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL load %0d pulse width: got ld_valid=%b want 0", i, ld_valid);
      end
    end
    access(1'b0, {3'd3, 12'h010}, 32'h0, c);
    n_cmp++;
    if (r_valid !== 1'b1 || r_data !== 32'h0) begin
      n_bad++;
      $display("FAIL load read: got v=%b %h want v=1 0", r_valid, r_data);
    end
  endtask

  task automatic test_back_to_back();
    int c, dc;
    run_job(1'b1, 4'b1111, 24'($urandom), "b2b-first");
    start_k.delete(); start_c.delete();
    access(1'b1, op_addr(1), 32'h0, c);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b done hold: got %b want 1", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b restart: got done=%b busy=%b want 0/1", done, busy);
    end
    wait_done(400, dc);
    @(negedge clk);
    check_order(4'b1111, "b2b-second");
  endtask

`ifdef STAGE_TIMEOUT_EN
  task automatic test_timeout();
    int c, a0;
    logic [31:0] st;
    logic v;
    auto_done = 1'b0;
    access(1'b1, op_addr(4), 32'h1, c);
    a0 = abort_n;
    access(1'b1, op_addr(1), 32'h0, c);
    for (int i = 0; i < 100 && abort_n == a0; i++) @(negedge clk);
    n_cmp++;
    if (abort_n != a0 + 1 || abort_c != c + 19) begin
      n_bad++;
      $display("FAIL timeout abort: got n=%0d @%0d want n=1 @%0d", abort_n - a0, abort_c, c + 19);
    end
    read_op(3, st, v);
    n_cmp++;
    if (st[15] !== 1'b1 || st[11] !== 1'b0 || st[10] !== 1'b0 || st[6:4] !== 3'd0) begin
      n_bad++;
      $display("FAIL timeout status: got %h want err3=1 done=0 busy=0 idle", st);
    end
    auto_done = 1'b1;
    access(1'b1, op_addr(5), 32'h0, c);
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_all_stages();
    test_mask();
    test_busy_errors();
    test_soft_rst();
    test_back_to_back();
`ifdef STAGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
